// File: rtl/branch_pkg.sv
// Shared types and constants for the branch resolve/predict unit.
package branch_pkg;

  // Branch condition codes as presented by execute.
  typedef enum logic [1:0] {
    NE   = 2'd0,
    ALU  = 2'd1,
    NALU = 2'd2,
    AL   = 2'd3
  } branch_cond_t;

  // 2-bit saturating counter states; bit 1 is the predicted direction.
  localparam logic [1:0] SNT = 2'd0;
  localparam logic [1:0] WNT = 2'd1;
  localparam logic [1:0] WT  = 2'd2;
  localparam logic [1:0] ST  = 2'd3;

  localparam logic [1:0] CtrResetVal = WNT;

  // Evaluate a branch condition given whether the ALU result is non-zero.
  function automatic logic eval_cond(input branch_cond_t cond, input logic alu_nz);
    logic taken;
    unique case (cond)
      NE:      taken = 1'b0;
      ALU:     taken = alu_nz;
      NALU:    taken = ~alu_nz;
      AL:      taken = 1'b1;
      default: taken = 1'b0;
    endcase
    return taken;
  endfunction

  // Only data-dependent branches train the table.
  function automatic logic trains_table(input branch_cond_t cond);
    return (cond == ALU) || (cond == NALU);
  endfunction

endpackage

// File: rtl/branch_sat_ctr.sv
// 2-bit saturating counter next-state function.
module branch_sat_ctr
  import branch_pkg::*;
(
  input  logic [1:0] cur,
  input  logic       taken,
  input  logic       en,
  output logic [1:0] nxt
);

  // Step towards strong-taken or strong-not-taken, holding at the ends.
  always_comb begin
    nxt = cur;
    if (en) begin
      if (taken) begin
        if (cur != ST) nxt = cur + 2'd1;
      end else begin
        if (cur != SNT) nxt = cur - 2'd1;
      end
    end
  end

endmodule

// File: rtl/branch_resolve_predict.sv
// Branch unit: resolves outcomes from execute, trains a PC-indexed table of
// 2-bit counters and serves registered predictions to fetch.
module branch_resolve_predict
  import branch_pkg::*;
#(
  parameter int unsigned WordSize   = 32,
  parameter int unsigned IndexBits  = 6,
  parameter int unsigned CountWidth = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  pred_req,
  input  logic [WordSize-1:0]   pred_pc,
  output logic                  pred_valid,
  output logic                  pred_taken,
  input  logic                  res_valid,
  input  logic [WordSize-1:0]   res_pc,
  input  logic [WordSize-1:0]   res_alu_out,
  input  logic [1:0]            res_branch_cond,
  input  logic                  res_pred_taken,
  output logic                  br_valid,
  output logic                  br_taken,
  output logic                  mispredict,
  output logic [CountWidth-1:0] mispredict_count
);

  localparam int unsigned Depth = 2 ** IndexBits;

  logic [1:0] ctr_q [Depth];
  logic [1:0] ctr_d [Depth];

  logic                  pred_valid_q, pred_valid_d;
  logic                  pred_taken_q, pred_taken_d;
  logic                  br_valid_q, br_valid_d;
  logic                  br_taken_q, br_taken_d;
  logic                  mispredict_q, mispredict_d;
  logic [CountWidth-1:0] count_q, count_d;

  branch_cond_t         cond;
  logic [IndexBits-1:0] pred_idx;
  logic [IndexBits-1:0] res_idx;
  logic                 outcome;
  logic                 upd_en;
  logic [1:0]           ctr_cur;
  logic [1:0]           ctr_nxt;
  logic [1:0]           pred_ctr;

  // PC bits outside the index window do not affect the table.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{pred_pc[WordSize-1:IndexBits+2], pred_pc[1:0],
                            res_pc[WordSize-1:IndexBits+2], res_pc[1:0]};

  assign cond     = branch_cond_t'(res_branch_cond);
  assign pred_idx = pred_pc[IndexBits+1:2];
  assign res_idx  = res_pc[IndexBits+1:2];

  // Resolve the branch and decide whether it trains the table.
  always_comb begin
    outcome = eval_cond(cond, |res_alu_out);
    upd_en  = res_valid & trains_table(cond);
  end

  assign ctr_cur = ctr_q[res_idx];

  branch_sat_ctr u_sat_ctr (
    .cur   (ctr_cur),
    .taken (outcome),
    .en    (upd_en),
    .nxt   (ctr_nxt)
  );

  // Table next state: only the resolving entry can change.
  always_comb begin
    ctr_d = ctr_q;
    if (upd_en) ctr_d[res_idx] = ctr_nxt;
  end

  // Prediction lookup; a same-index update is bypassed so fetch sees the new value.
  always_comb begin
    pred_ctr     = (upd_en && (res_idx == pred_idx)) ? ctr_nxt : ctr_q[pred_idx];
    pred_valid_d = pred_req;
    pred_taken_d = pred_req & pred_ctr[1];
  end

  // Resolution outputs and the saturating mispredict statistic.
  always_comb begin
    br_valid_d   = res_valid;
    br_taken_d   = res_valid & outcome;
    mispredict_d = res_valid & (outcome != res_pred_taken);
    count_d      = count_q;
    if (mispredict_d && !(&count_q)) count_d = count_q + 1'b1;
  end

  // Counter table state.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < Depth; i++) ctr_q[i] <= CtrResetVal;
    end else begin
      ctr_q <= ctr_d;
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pred_valid_q <= 1'b0;
      pred_taken_q <= 1'b0;
      br_valid_q   <= 1'b0;
      br_taken_q   <= 1'b0;
      mispredict_q <= 1'b0;
      count_q      <= '0;
    end else begin
      pred_valid_q <= pred_valid_d;
      pred_taken_q <= pred_taken_d;
      br_valid_q   <= br_valid_d;
      br_taken_q   <= br_taken_d;
      mispredict_q <= mispredict_d;
      count_q      <= count_d;
    end
  end

  assign pred_valid       = pred_valid_q;
  assign pred_taken       = pred_taken_q;
  assign br_valid         = br_valid_q;
  assign br_taken         = br_taken_q;
  assign mispredict       = mispredict_q;
  assign mispredict_count = count_q;

endmodule
